// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer:
// operation encodings, FSM states and the Alu opcodes it drives.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULTU = 2'd0,
        OP_MULT  = 2'd1,
        OP_DIVU  = 2'd2,
        OP_DIV   = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        ABS_A,
        ABS_B,
        ITER,
        FIX_LO,
        FIX_HI,
        FIX_INC,
        DONE
    } state_e;

    // Alu opcodes, shared with the instruction decoder
    localparam logic [3:0] ALU_ADD = 4'd5;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_NOR = 4'd10;

    // op[1] selects divide, op[0] selects signed
    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return op[0];
    endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// Request/result and shared-Alu signals between the EX stage and the
// multiply/divide sequencer.
interface muldiv_seq_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_zero;
    logic [31:0] alu_x;
    logic [31:0] alu_y;
    logic [3:0]  alu_op;
    logic [31:0] alu_result;

    // EX stage side: issues requests and owns the Alu
    modport master (
        output start, op, a, b, alu_result,
        input  busy, done, hi, lo, div_zero, alu_x, alu_y, alu_op
    );

    // Sequencer side
    modport slave (
        input  start, op, a, b, alu_result,
        output busy, done, hi, lo, div_zero, alu_x, alu_y, alu_op
    );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU sequencer. Every add, subtract and
// NOR is done by the parent's shared combinational Alu; this block only
// steers its inputs and captures its result. Latency is fixed per class:
// 33 cycles unsigned, 38 signed, 1 for divide-by-zero.
module muldiv_seq
    import muldiv_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    muldiv_seq_if.slave bus
);

    state_e      state_reg;
    logic [1:0]  op_reg;
    logic        neg_q_reg;
    logic        neg_r_reg;
    logic [31:0] ma_reg;
    logic [31:0] mb_reg;
    logic [31:0] hi_reg;
    logic [31:0] lo_reg;
    logic [4:0]  count_reg;
    logic        busy_reg;
    logic        done_reg;
    logic        div_zero_reg;

    logic        is_div;
    logic        is_signed;
    logic        start_div;
    logic        start_signed;

    logic [31:0] iter_r;
    logic        iter_ovf;
    logic        iter_take;
    logic        mul_carry;
    logic [31:0] mb_abs;

    logic [31:0] alu_x;
    logic [31:0] alu_y;
    logic [3:0]  alu_op;

    assign is_div       = op_is_div(op_reg);
    assign is_signed    = op_is_signed(op_reg);
    assign start_div    = op_is_div(bus.op);
    assign start_signed = op_is_signed(bus.op);

    // Restoring divide step: shifted partial remainder with its 33rd bit
    // kept separately; a set top bit means the subtract always fits.
    assign iter_r    = {hi_reg[30:0], lo_reg[31]};
    assign iter_ovf  = hi_reg[31];
    assign iter_take = iter_ovf | (iter_r >= mb_reg);

    // Carry out of hi + ma, recovered from wrap-around of the Alu sum
    assign mul_carry = (bus.alu_result < hi_reg);

    // Magnitude of the divisor/multiplier as seen in ABS_B
    assign mb_abs = mb_reg[31] ? bus.alu_result : mb_reg;

    // Alu input steering; must follow the current state combinationally
    // because the result is consumed in the same cycle.
    always_comb begin
        alu_x  = 32'd0;
        alu_y  = 32'd0;
        alu_op = ALU_ADD;
        case (state_reg)
            ABS_A: begin
                alu_y  = ma_reg;
                alu_op = ALU_SUB;
            end
            ABS_B: begin
                alu_y  = mb_reg;
                alu_op = ALU_SUB;
            end
            ITER: begin
                if (is_div) begin
                    alu_x  = iter_r;
                    alu_y  = mb_reg;
                    alu_op = ALU_SUB;
                end else begin
                    alu_x  = hi_reg;
                    alu_y  = ma_reg;
                    alu_op = ALU_ADD;
                end
            end
            FIX_LO: begin
                alu_y  = lo_reg;
                alu_op = ALU_SUB;
            end
            FIX_HI: begin
                if (is_div) begin
                    alu_y  = hi_reg;
                    alu_op = ALU_SUB;
                end else begin
                    alu_x  = hi_reg;
                    alu_y  = hi_reg;
                    alu_op = ALU_NOR;
                end
            end
            FIX_INC: begin
                if (!is_div) begin
                    alu_x  = hi_reg;
                    alu_y  = 32'd1;
                    alu_op = ALU_ADD;
                end
            end
            default: begin
                alu_x  = 32'd0;
                alu_y  = 32'd0;
                alu_op = ALU_ADD;
            end
        endcase
    end

    // Sequencer FSM with its datapath registers and status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            op_reg       <= 2'd0;
            neg_q_reg    <= 1'b0;
            neg_r_reg    <= 1'b0;
            ma_reg       <= 32'd0;
            mb_reg       <= 32'd0;
            hi_reg       <= 32'd0;
            lo_reg       <= 32'd0;
            count_reg    <= 5'd0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            div_zero_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        op_reg    <= bus.op;
                        neg_q_reg <= start_signed & (bus.a[31] ^ bus.b[31]);
                        neg_r_reg <= start_signed & bus.a[31];
                        ma_reg    <= bus.a;
                        mb_reg    <= bus.b;
                        count_reg <= 5'd0;
                        busy_reg  <= 1'b1;
                        if (start_div && (bus.b == 32'd0)) begin
                            hi_reg       <= bus.a;
                            lo_reg       <= 32'hFFFF_FFFF;
                            div_zero_reg <= 1'b1;
                            done_reg     <= 1'b1;
                            state_reg    <= DONE;
                        end else begin
                            div_zero_reg <= 1'b0;
                            if (start_signed) begin
                                state_reg <= ABS_A;
                            end else begin
                                hi_reg    <= 32'd0;
                                lo_reg    <= start_div ? bus.a : bus.b;
                                state_reg <= ITER;
                            end
                        end
                    end
                end
                ABS_A: begin
                    if (ma_reg[31]) begin
                        ma_reg <= bus.alu_result;
                    end
                    state_reg <= ABS_B;
                end
                ABS_B: begin
                    mb_reg    <= mb_abs;
                    hi_reg    <= 32'd0;
                    lo_reg    <= is_div ? ma_reg : mb_abs;
                    state_reg <= ITER;
                end
                ITER: begin
                    if (is_div) begin
                        if (iter_take) begin
                            hi_reg <= bus.alu_result;
                            lo_reg <= {lo_reg[30:0], 1'b1};
                        end else begin
                            hi_reg <= iter_r;
                            lo_reg <= {lo_reg[30:0], 1'b0};
                        end
                    end else begin
                        if (lo_reg[0]) begin
                            hi_reg <= {mul_carry, bus.alu_result[31:1]};
                            lo_reg <= {bus.alu_result[0], lo_reg[31:1]};
                        end else begin
                            hi_reg <= {1'b0, hi_reg[31:1]};
                            lo_reg <= {hi_reg[0], lo_reg[31:1]};
                        end
                    end
                    count_reg <= count_reg + 5'd1;
                    if (count_reg == 5'd31) begin
                        if (is_signed) begin
                            state_reg <= FIX_LO;
                        end else begin
                            done_reg  <= 1'b1;
                            state_reg <= DONE;
                        end
                    end
                end
                FIX_LO: begin
                    if (neg_q_reg) begin
                        lo_reg <= bus.alu_result;
                    end
                    state_reg <= FIX_HI;
                end
                FIX_HI: begin
                    if (is_div ? neg_r_reg : neg_q_reg) begin
                        hi_reg <= bus.alu_result;
                    end
                    state_reg <= FIX_INC;
                end
                FIX_INC: begin
                    // Two's-complement of the 64-bit product: carry into hi
                    // only when the negated low word is zero.
                    if (!is_div && neg_q_reg && (lo_reg == 32'd0)) begin
                        hi_reg <= bus.alu_result;
                    end
                    done_reg  <= 1'b1;
                    state_reg <= DONE;
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = busy_reg;
    assign bus.done     = done_reg;
    assign bus.hi       = hi_reg;
    assign bus.lo       = lo_reg;
    assign bus.div_zero = div_zero_reg;
    assign bus.alu_x    = alu_x;
    assign bus.alu_y    = alu_y;
    assign bus.alu_op   = alu_op;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: a behavioural Alu closes the loop,
// a reference model fills a scoreboard at issue time and each done pops it.
module tb_muldiv_seq;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    muldiv_seq_if bus();

    muldiv_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Parent-side Alu
    always_comb begin
        case (bus.alu_op)
            4'd5:    bus.alu_result = bus.alu_x + bus.alu_y;
            4'd6:    bus.alu_result = bus.alu_x - bus.alu_y;
            4'd10:   bus.alu_result = ~(bus.alu_x | bus.alu_y);
            default: bus.alu_result = 32'd0;
        endcase
    end

    exp_t sb[$];
    int errors   = 0;
    int checks   = 0;
    int done_cnt = 0;

    always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

    function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic [63:0] p;
        logic signed [63:0] sa;
        logic signed [63:0] sbv;
        e.dz = 1'b0;
        e.hi = 32'd0;
        e.lo = 32'd0;
        e.lat = 33;
        case (op)
            2'd0: begin
                p = {32'd0, a} * {32'd0, b};
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            2'd1: begin
                sa  = {{32{a[31]}}, a};
                sbv = {{32{b[31]}}, b};
                p = sa * sbv;
                e.hi = p[63:32];
                e.lo = p[31:0];
                e.lat = 38;
            end
            2'd2: begin
                if (b == 32'd0) begin
                    e.hi = a; e.lo = 32'hFFFF_FFFF; e.dz = 1'b1; e.lat = 1;
                end else begin
                    e.lo = a / b;
                    e.hi = a % b;
                end
            end
            default: begin
                if (b == 32'd0) begin
                    e.hi = a; e.lo = 32'hFFFF_FFFF; e.dz = 1'b1; e.lat = 1;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    e.lo = 32'h8000_0000; e.hi = 32'd0; e.lat = 38;
                end else begin
                    e.lo = $signed(a) / $signed(b);
                    e.hi = $signed(a) % $signed(b);
                    e.lat = 38;
                end
            end
        endcase
        return e;
    endfunction

    // Issue one op, optionally pulse stray starts at cycles 5 and 33, then check
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit glitch, input string name);
        exp_t e;
        int cyc;
        int dc0;
        bit busy_ok;
        bit got_done;
        sb.push_back(model(op, a, b));
        dc0 = done_cnt;
        bus.op = op; bus.a = a; bus.b = b; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 1;
        busy_ok = 1'b1;
        got_done = 1'b0;
        while (cyc < 80) begin
            if (glitch && (cyc == 5 || cyc == 33)) begin
                bus.start = 1'b1; bus.op = ~op; bus.a = $urandom; bus.b = $urandom;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.done === 1'b1) begin
                got_done = 1'b1;
                break;
            end
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (!got_done) begin
            errors++;
            $display("FAIL %s done_timeout: no done within %0d cycles", name, cyc);
            sb.delete();
            bus.start = 1'b0;
            return;
        end
        e = sb.pop_front();
        checks++;
        if (cyc !== e.lat) begin
            errors++; $display("FAIL %s latency: got %0d want %0d", name, cyc, e.lat);
        end
        checks++;
        if (bus.hi !== e.hi) begin
            errors++; $display("FAIL %s hi: got %h want %h", name, bus.hi, e.hi);
        end
        checks++;
        if (bus.lo !== e.lo) begin
            errors++; $display("FAIL %s lo: got %h want %h", name, bus.lo, e.lo);
        end
        checks++;
        if (bus.div_zero !== e.dz) begin
            errors++; $display("FAIL %s div_zero: got %b want %b", name, bus.div_zero, e.dz);
        end
        checks++;
        if (bus.busy !== 1'b1 || busy_ok !== 1'b1) begin
            errors++; $display("FAIL %s busy_window: busy_at_done %b steady %b want 1 1", name, bus.busy, busy_ok);
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++; $display("FAIL %s after_done: busy %b done %b want 0 0", name, bus.busy, bus.done);
        end
        checks++;
        if (bus.hi !== e.hi || bus.lo !== e.lo) begin
            errors++; $display("FAIL %s hold: hi %h lo %h want %h %h", name, bus.hi, bus.lo, e.hi, e.lo);
        end
        checks++;
        if (done_cnt - dc0 !== 1) begin
            errors++; $display("FAIL %s done_pulses: got %0d want 1", name, done_cnt - dc0);
        end
        checks++;
        if (bus.alu_x !== 32'd0 || bus.alu_y !== 32'd0 || bus.alu_op !== 4'd5) begin
            errors++; $display("FAIL %s alu_idle: x %h y %h op %0d want 0 0 5", name, bus.alu_x, bus.alu_y, bus.alu_op);
        end
        $display("%s op=%0d a=%h b=%h -> hi=%h lo=%h dz=%b cyc=%0d", name, op, a, b, bus.hi, bus.lo, bus.div_zero, cyc);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0; bus.op = 2'd0; bus.a = 32'd0; bus.b = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.div_zero !== 1'b0) begin
            errors++; $display("FAIL reset_flags: busy %b done %b dz %b want 0 0 0", bus.busy, bus.done, bus.div_zero);
        end
        checks++;
        if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            errors++; $display("FAIL reset_hilo: hi %h lo %h want 0 0", bus.hi, bus.lo);
        end
        checks++;
        if (bus.alu_x !== 32'd0 || bus.alu_y !== 32'd0 || bus.alu_op !== 4'd5) begin
            errors++; $display("FAIL reset_alu: x %h y %h op %0d want 0 0 5", bus.alu_x, bus.alu_y, bus.alu_op);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        $display("reset: busy=%b done=%b hi=%h lo=%h", bus.busy, bus.done, bus.hi, bus.lo);
    endtask

    task automatic test_mult();
        run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu_max");
        run_op(2'd1, 32'hFFFF_FFFD, 32'd7, 1'b0, "mult_neg3x7");
        run_op(2'd1, 32'hFFFF_FFFB, 32'd0, 1'b0, "mult_neg5x0");
    endtask

    task automatic test_div();
        run_op(2'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_neg7by2");
        run_op(2'd2, 32'd100, 32'd7, 1'b0, "divu_100by7");
        run_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_minby_neg1");
    endtask

    task automatic test_div_zero();
        run_op(2'd2, 32'd100, 32'd0, 1'b0, "divu_by_zero");
        run_op(2'd2, 32'd100, 32'd7, 1'b0, "divu_clears_dz");
        run_op(2'd3, 32'hFFFF_FFF0, 32'd0, 1'b0, "div_by_zero");
    endtask

    task automatic test_reset_midop();
        int dc0;
        bus.op = 2'd0; bus.a = 32'hFFFF_FFFF; bus.b = 32'd123; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        dc0 = done_cnt;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            errors++; $display("FAIL midop_reset: busy %b done %b hi %h lo %h want 0 0 0 0", bus.busy, bus.done, bus.hi, bus.lo);
        end
        checks++;
        if (bus.alu_op !== 4'd5 || bus.alu_x !== 32'd0 || bus.alu_y !== 32'd0) begin
            errors++; $display("FAIL midop_reset_alu: x %h y %h op %0d want 0 0 5", bus.alu_x, bus.alu_y, bus.alu_op);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        checks++;
        if (done_cnt !== dc0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL midop_dropped: done pulses %0d busy %b want 0 0", done_cnt - dc0, bus.busy);
        end
        $display("reset_midop: busy=%b hi=%h lo=%h", bus.busy, bus.hi, bus.lo);
        run_op(2'd0, 32'd6, 32'd7, 1'b0, "multu_6x7_after_rst");
    endtask

    task automatic test_ignored_start();
        run_op(2'd0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, "multu_ignore_start");
        run_op(2'd3, 32'd1000, 32'hFFFF_FFFD, 1'b1, "div_ignore_start");
    endtask

    task automatic test_back_to_back();
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 10; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = (i % 4 == 3) ? 32'($urandom_range(0, 3)) : $urandom;
            if (i % 3 == 1) b = b >> 20;
            run_op(op, a, b, 1'b0, "b2b_random");
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_reset_midop();
        test_ignored_start();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative 32-bit multiply/divide sequencer implementing MULT, MULTU, DIV and DIVU by driving the shared combinational Alu for every add, subtract and NOR step. Results go to HI/LO. It sits beside the EX stage. While `busy` is high, the parent stalls the pipeline and muxes the Alu's X/Y/AluOP inputs from this block. Latency is fixed per operation class, so the stall logic can rely on `done`.

## Interface
Parameters: none; width fixed at 32.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request; sampled only in IDLE.
- `op` in 2: 0 MULTU, 1 MULT, 2 DIVU, 3 DIV.
- `a`, `b` in 32: operands (multiplicand/multiplier, or dividend/divisor); sampled with `start`.
- `busy` out 1: high from the cycle after acceptance until `done`, inclusive.
- `done` out 1: one-cycle pulse; `hi`/`lo` are valid from this cycle on.
- `hi`, `lo` out 32 each: product high/low, or remainder/quotient; held until the next accepted start.
- `div_zero` out 1: set with `done` when a DIV/DIVU had `b==0`; cleared on the next accepted start.
- `alu_x`, `alu_y` out 32, `alu_op` out 4: drive to Alu X, Y, AluOP.
- `alu_result` in 32: Alu Result, combinational from `alu_*`, consumed in the same cycle.

## Operation
- **Alu codes used:** 5 add, 6 sub, 10 nor. In IDLE/DONE: `alu_x=alu_y=0`, `alu_op=5`.
- **IDLE + start:**
  - Latch `op`.
  - Set `neg_q = a[31]^b[31]` and `neg_r = a[31]`; both forced 0 for unsigned ops.
  - Load `ma=a`, `mb=b`.
  - DIV/DIVU with `b==0`: go to DONE with `hi=a`, `lo=32'hFFFFFFFF`, `div_zero=1`.
  - Otherwise, signed ops go to ABS_A; unsigned ops go to ITER.
- **ABS_A:** Alu computes 0−ma (op 6). If `ma[31]`, write the result to `ma`.
- **ABS_B:** same for `mb`. Then load `hi=0`, `lo=` multiplier `mb` for multiply, or dividend `ma` for divide. Go to ITER. For unsigned ops this same load happens at acceptance.
- **ITER:** 5-bit counter, 32 cycles.
  - Multiply (shift-add):
    - When `lo[0]`: `alu_x=hi`, `alu_y=ma`, op 5. Carry is `(alu_result < hi)` unsigned, compared internally. Then `{hi,lo} <= {carry, alu_result, lo[31:1]}`.
    - When `lo[0]==0`: `{hi,lo} <= {1'b0, hi, lo[31:1]}`.
  - Divide (restoring):
    - Form `r={hi[30:0],lo[31]}` and `ovf=hi[31]`; `alu_x=r`, `alu_y=mb`, op 6.
    - If `ovf | (r >= mb)`: `hi<=alu_result`, `lo<={lo[30:0],1}`.
    - Else: `hi<=r`, `lo<={lo[30:0],0}`.
  - After the 32nd cycle: signed ops go to FIX_LO; unsigned ops go to DONE.
- **FIX_LO:** op 6, `0−lo`; written if `neg_q`.
- **FIX_HI:**
  - Multiply: op 10 NOR(hi,hi), written if `neg_q`.
  - Divide: op 6, `0−hi`, written if `neg_r`.
- **FIX_INC:**
  - Multiply: op 5, `hi+1`, written if `neg_q && lo==0`.
  - Divide: no write.
- **DONE:** `done=1` for one cycle, then IDLE.
- **Edge case:** DIV 0x80000000 / −1 gives `lo=0x80000000`, `hi=0`, with no flag.

## Timing
- Acceptance edge is cycle 0. `done` is high at:
  - cycle 33 for unsigned ops (ITER runs cycles 1–32);
  - cycle 38 for signed ops (ABS 1–2, ITER 3–34, FIX 35–37);
  - cycle 1 for divide-by-zero.
- Each FSM state is exactly one cycle long. The latency is independent of operand values.
- `start` while busy is ignored, not queued. `start` in the DONE cycle is also ignored. The earliest restart is the cycle after `done`.
- Reset at any time:
  - state returns to IDLE;
  - counter cleared;
  - `busy=done=div_zero=0`, `hi=lo=0`;
  - `alu_x=alu_y=0`, `alu_op=5`;
  - an in-flight operation is dropped without a `done`.
- `hi`/`lo` change during busy and are undefined to consumers until `done`.

## Structure
- **Package `muldiv_pkg`:**
  - op encodings MULTU/MULT/DIVU/DIV;
  - FSM state enum IDLE, ABS_A, ABS_B, ITER, FIX_LO, FIX_HI, FIX_INC, DONE;
  - Alu opcode constants ALU_ADD=5, ALU_SUB=6, ALU_NOR=10, shared with the decoder.
- Single module, no sub-module. The Alu is instantiated by the parent, not inside this block.

## Test plan
- MULTU `0xFFFFFFFF × 0xFFFFFFFF` → `hi=0xFFFFFFFE`, `lo=0x00000001`, `done` at cycle 33, `busy` high cycles 1–33.
- MULT `−3 × 7` → `hi=0xFFFFFFFF`, `lo=0xFFFFFFEB` at cycle 38. MULT `−5 × 0` → `hi=lo=0`, which exercises FIX_INC.
- DIV `−7 / 2` → `lo=0xFFFFFFFD`, `hi=0xFFFFFFFF`. DIVU `100 / 7` → `lo=14`, `hi=2`, `done` at cycle 33.
- DIVU `100 / 0` → `done` at cycle 1, `div_zero=1`, `hi=100`, `lo=0xFFFFFFFF`. The next valid op clears `div_zero`.
- Assert `rst` at cycle 10 of a MULTU → `busy=0`, no `done`, `hi=lo=0`. A new MULTU `6×7` then gives `lo=42` at cycle 33.
- Pulse `start` with different operands at cycles 5 and 33 of an op → both ignored; the original result holds and `done` fires exactly once.
